// File: rtl/led_display_scheduler.sv
// led_display_scheduler
//
// Shares one LED bank between N_SRC requesters. A round-robin arbiter hands
// the bank to one source at a time. Each grant lasts DWELL_TICKS slow ticks,
// or ends sooner if the owner drops its request. When nobody is requesting,
// the bank shows a fill/drain walking pattern.
//
// All timing runs on clk. A clock-enable tick, one cycle high every TICK_DIV
// clocks, stands in for a derived slow clock.
//
// Optional build macro: LED_SCHED_LIVE_EN
//   defined   : in SHOW, led follows src_data of the owner with one registered
//               cycle of lag.
//   undefined : led is latched at grant and stays static for the whole slice.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   src_req   per-source level request
//   src_data  per-source pattern, source i at [i*LED_W +: LED_W]
//   src_gnt   one-hot grant (registered), zero when nobody owns the LEDs
//   src_done  one-cycle pulse to the source whose slice just ended
//   led       LED drive (registered)
//   busy      high in SHOW and RELEASE
module led_display_scheduler #(
  parameter int N_SRC       = 3,
  parameter int LED_W       = 4,
  parameter int TICK_DIV    = 100000000,
  parameter int DWELL_TICKS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       src_req,
  input  logic [N_SRC*LED_W-1:0] src_data,
  output logic [N_SRC-1:0]       src_gnt,
  output logic [N_SRC-1:0]       src_done,
  output logic [LED_W-1:0]       led,
  output logic                   busy
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int STEP_W = $clog2(2 * LED_W);
  localparam int DW_W   = $clog2(DWELL_TICKS + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(2 * LED_W - 1);
  localparam logic [DW_W-1:0]   DW_LAST   = DW_W'(DWELL_TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_SRC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Idle pattern step k lights min(k, 2*LED_W-k) LEDs, filled from the MSB.
  function automatic logic [LED_W-1:0] pattern(input logic [STEP_W-1:0] k);
    int kk;
    int ones;
    kk   = int'(k);
    ones = (kk <= LED_W) ? kk : (2 * LED_W - kk);
    pattern = '0;
    for (int i = 0; i < LED_W; i++) begin
      pattern[LED_W-1-i] = (i < ones);
    end
  endfunction

  function automatic logic [N_SRC-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  state_t            state, state_n;
  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  logic [STEP_W-1:0] step, step_n;
  logic [DW_W-1:0]   dwell, dwell_n;
  logic [IDX_W-1:0]  gidx, gidx_n;
  logic [IDX_W-1:0]  last_grant, last_n;
  logic [N_SRC-1:0]  gnt_n, done_n;
  logic [LED_W-1:0]  led_n;
  logic              busy_n;
  logic              found;
  logic [IDX_W-1:0]  sel;

  // Free-running tick generator. It restarts only on reset.
  assign tick = (tick_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  // Round-robin search: start at the source after the last owner. A source
  // that holds its request therefore waits behind every other requester.
  always_comb begin
    int cand;
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int off = 1; off <= N_SRC; off++) begin
      cand = (int'(last_grant) + off) % N_SRC;
      if (!found && src_req[cand]) begin
        found = 1'b1;
        sel   = IDX_W'(cand);
      end
    end
  end

  // Next-state logic. Every output register gets the value it should carry
  // in the next state, so led, src_gnt, src_done and busy all come straight
  // from flops.
  always_comb begin
    state_n = state;
    gnt_n   = src_gnt;
    done_n  = '0;
    led_n   = led;
    busy_n  = busy;
    step_n  = step;
    dwell_n = dwell;
    gidx_n  = gidx;
    last_n  = last_grant;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = SHOW;
          gnt_n   = onehot(sel);
          led_n   = src_data[int'(sel)*LED_W +: LED_W];
          dwell_n = '0;
          gidx_n  = sel;
          busy_n  = 1'b1;
        end else begin
          if (tick) step_n = (step == STEP_LAST) ? '0 : step + 1'b1;
          led_n = pattern(step_n);
        end
      end
      SHOW: begin
`ifdef LED_SCHED_LIVE_EN
        led_n = src_data[int'(gidx)*LED_W +: LED_W];
`endif
        if (tick) dwell_n = dwell + 1'b1;
        // Expiry and early release can coincide; both lead to one RELEASE.
        if ((tick && (dwell == DW_LAST)) || !src_req[gidx]) begin
          state_n = RELEASE;
          gnt_n   = '0;
          done_n  = onehot(gidx);
        end
      end
      RELEASE: begin
        state_n = IDLE;
        last_n  = gidx;
        step_n  = '0;
        led_n   = pattern('0);
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src_gnt    <= '0;
      src_done   <= '0;
      led        <= '0;
      busy       <= 1'b0;
      step       <= '0;
      dwell      <= '0;
      gidx       <= '0;
      last_grant <= IDX_LAST;
    end else begin
      state      <= state_n;
      src_gnt    <= gnt_n;
      src_done   <= done_n;
      led        <= led_n;
      busy       <= busy_n;
      step       <= step_n;
      dwell      <= dwell_n;
      gidx       <= gidx_n;
      last_grant <= last_n;
    end
  end

endmodule
